// File: rtl/parse_stream.sv
// parse_stream: 12-bit rejection sampler turning an XOF byte stream into N coefficients in [0, Q).
// Define PARSE_STREAM_REJ_STATS_EN to add the o_rej_cnt rejected-candidate counter.
module parse_stream #(
   parameter int IN_BYTES = 8,
   parameter int LANES    = 4,
   parameter int N        = 256,
   parameter int Q        = 3329,
   parameter int CW       = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [8*IN_BYTES-1:0] i_ibytes,
   input  logic                  i_ibytes_valid,
   output logic                  o_ibytes_ready,
   output logic [LANES*CW-1:0]   o_coeffs,
   output logic                  o_coeffs_valid,
   input  logic                  i_coeffs_ready,
   output logic                  o_busy,
   output logic                  o_done
`ifdef PARSE_STREAM_REJ_STATS_EN
   ,
   output logic [15:0]           o_rej_cnt
`endif
);
   localparam int G   = LANES / 2;
   localparam int GB  = 3 * G;
   localparam int BUF = IN_BYTES + GB;
   localparam int SD  = 2 * LANES - 1;
   localparam int AW  = $clog2(N + 1);
   localparam int BW  = $clog2(BUF + 1);
   localparam int SW  = $clog2(SD + 1);
   localparam logic [CW:0] QV = Q[CW:0];

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state;
   logic [8*BUF-1:0]    buf_q, buf_n, buf_pop;
   logic [BW-1:0]       buf_cnt, buf_cnt_p, buf_cnt_n;
   logic [CW*SD-1:0]    stg_q, stg_n;
   logic [SW-1:0]       stg_cnt, stg_kept, stg_cnt_n;
   logic [AW-1:0]       acc_cnt, acc_n;
   logic [CW-1:0]       cand [LANES];
   logic [LANES*CW-1:0] beat;
   logic                push, move, process;
`ifdef PARSE_STREAM_REJ_STATS_EN
   logic [$clog2(LANES+1)-1:0] rej_add;
   logic [16:0]                rej_sum;
   logic [15:0]                rej_n;
`endif

   // Group bytes {b0, b1, b2} -> {d1, d2}
   function automatic logic [2*CW-1:0] split_group(input logic [23:0] grp);
      return {CW'({grp[11:8], grp[23:16]}), CW'({grp[7:0], grp[15:12]})};
   endfunction

   // NOTE: every signal gets a default at the top of the block so no path leaves one unassigned (no latches).
   always_comb begin
      push     = o_ibytes_ready && i_ibytes_valid;
      move     = (stg_cnt >= SW'(LANES)) && (!o_coeffs_valid || i_coeffs_ready);
      stg_kept = move ? stg_cnt - SW'(LANES) : stg_cnt;
      process  = (state == RUN) && (buf_cnt >= BW'(GB)) && (stg_kept < SW'(LANES));

      for (int g = 0; g < G; g++)
         {cand[2*g], cand[2*g+1]} = split_group(buf_q[8*(BUF-3*g)-1 -: 24]);
      beat = stg_q[CW*SD-1 -: CW*LANES];

      // Byte 0 of the buffer sits in the MSBs; bytes past the live count are masked off before a push.
      buf_cnt_p = process ? buf_cnt - BW'(GB) : buf_cnt;
      buf_pop   = process ? buf_q << (8*GB) : buf_q;
      buf_n     = buf_pop & ~({(8*BUF){1'b1}} >> {buf_cnt_p, 3'b000});
      buf_cnt_n = buf_cnt_p;
      if (push) begin
         buf_n     = buf_n | ({i_ibytes, {(8*GB){1'b0}}} >> {buf_cnt_p, 3'b000});
         buf_cnt_n = buf_cnt_p + BW'(IN_BYTES);
      end

      stg_n     = move ? stg_q << (CW*LANES) : stg_q;
      stg_cnt_n = stg_kept;
      acc_n     = acc_cnt;
`ifdef PARSE_STREAM_REJ_STATS_EN
      rej_add   = '0;
`endif
      // NOTE: blocking updates of stg_cnt_n/acc_n inside the loop give each candidate the running totals of the earlier ones.
      if (process) begin
         for (int c = 0; c < LANES; c++) begin
            if ({1'b0, cand[c]} < QV) begin
               if (acc_n < AW'(N)) begin
                  stg_n[CW*SD-1 - CW*int'(stg_cnt_n) -: CW] = cand[c];
                  stg_cnt_n = stg_cnt_n + SW'(1);
                  acc_n     = acc_n + AW'(1);
               end
            end
`ifdef PARSE_STREAM_REJ_STATS_EN
            else if (acc_n < AW'(N)) begin
               rej_add = rej_add + 1'b1;
            end
`endif
         end
      end
`ifdef PARSE_STREAM_REJ_STATS_EN
      rej_sum = {1'b0, o_rej_cnt} + 17'(rej_add);
      rej_n   = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= IDLE;
         buf_cnt        <= '0;
         stg_cnt        <= '0;
         acc_cnt        <= '0;
         o_ibytes_ready <= 1'b0;
         o_coeffs       <= '0;
         o_coeffs_valid <= 1'b0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
`ifdef PARSE_STREAM_REJ_STATS_EN
         o_rej_cnt      <= '0;
`endif
      end else begin
         o_done <= 1'b0;
         unique case (state)
            IDLE: if (i_start) begin
               state          <= RUN;
               buf_cnt        <= '0;
               stg_cnt        <= '0;
               acc_cnt        <= '0;
               o_ibytes_ready <= 1'b1;
               o_busy         <= 1'b1;
`ifdef PARSE_STREAM_REJ_STATS_EN
               o_rej_cnt      <= '0;
`endif
            end
            RUN, DRAIN: begin
               buf_cnt <= buf_cnt_n;
               stg_cnt <= stg_cnt_n;
               acc_cnt <= acc_n;
               // Ready is registered: only offered when a whole beat fits even if nothing pops next cycle.
               o_ibytes_ready <= (state == RUN) && (acc_n != AW'(N)) && (buf_cnt_n <= BW'(GB));
               if (move) begin
                  o_coeffs       <= beat;
                  o_coeffs_valid <= 1'b1;
               end else if (i_coeffs_ready) begin
                  o_coeffs_valid <= 1'b0;
               end
`ifdef PARSE_STREAM_REJ_STATS_EN
               o_rej_cnt <= rej_n;
`endif
               if (state == RUN && acc_n == AW'(N))
                  state <= DRAIN;
               if (state == DRAIN && stg_cnt == '0 && (!o_coeffs_valid || i_coeffs_ready)) begin
                  state  <= DONE;
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
               end
            end
            DONE: begin
               state   <= IDLE;
               buf_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the data stores are not reset; the occupancy counters alone decide which entries are live.
   always_ff @(posedge i_clk) begin
      buf_q <= buf_n;
      stg_q <= stg_n;
   end
endmodule

// File: tb/tb_parse_stream.sv
// Self-checking bench for parse_stream: directed runs plus random traffic against a software Parse model.
module tb_parse_stream;
   localparam int Q    = 3329;
   localparam int MAXC = 4000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start, ivalid, iready, cvalid, cready, busy, done;
   logic [63:0]  ibytes;
   logic [47:0]  coeffs;
   logic         b_start, b_ivalid, b_iready, b_cvalid, b_busy, b_done;
   logic [127:0] b_ibytes;
   logic [95:0]  b_coeffs;
`ifdef PARSE_STREAM_REJ_STATS_EN
   logic [15:0]  rej, b_rej;
`endif

   parse_stream u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_ibytes(ibytes), .i_ibytes_valid(ivalid),
      .o_ibytes_ready(iready), .o_coeffs(coeffs), .o_coeffs_valid(cvalid), .i_coeffs_ready(cready),
      .o_busy(busy), .o_done(done)
`ifdef PARSE_STREAM_REJ_STATS_EN
      , .o_rej_cnt(rej)
`endif
   );

   parse_stream #(.IN_BYTES(16), .LANES(8), .N(64)) u_big (
      .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_ibytes(b_ibytes), .i_ibytes_valid(b_ivalid),
      .o_ibytes_ready(b_iready), .o_coeffs(b_coeffs), .o_coeffs_valid(b_cvalid), .i_coeffs_ready(1'b1),
      .o_busy(b_busy), .o_done(b_done)
`ifdef PARSE_STREAM_REJ_STATS_EN
      , .o_rej_cnt(b_rej)
`endif
   );

   int n_err = 0;
   int n_chk = 0;
   int fed_q[$];
   int got_q[$];
   int exp_q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Software Parse: walk 3-byte groups, keep values below Q, stop at n coefficients.
   function automatic void build_model(input int n);
      exp_q.delete();
      for (int k = 0; k + 2 < fed_q.size() && exp_q.size() < n; k += 3) begin
         int d1, d2;
         d1 = fed_q[k] + 256 * (fed_q[k+1] % 16);
         d2 = fed_q[k+1] / 16 + 16 * fed_q[k+2];
         if (d1 < Q) exp_q.push_back(d1);
         if (d2 < Q && exp_q.size() < n) exp_q.push_back(d2);
      end
   endfunction

   function automatic int got_at(input int i);
      return (i < got_q.size()) ? got_q[i] : -1;
   endfunction

   function automatic logic [7:0] src_byte(input int mode, input int k);
      case (mode)
         1: case (k % 3)
               0:       return 8'h01;
               1:       return 8'h23;
               default: return 8'h45;
            endcase
         2: return 8'($urandom_range(255));
         3: return 8'hFF;
         4: case (k)
               1, 4:    return 8'h0D;
               3:       return 8'h01;
               default: return 8'h00;
            endcase
         default: return 8'h00;
      endcase
   endfunction

   task automatic compare_model(input string tag, input int n);
      build_model(n);
      check($sformatf("%s count", tag), 128'(got_q.size()), 128'(n));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s coeff[%0d]", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
   endtask

   task automatic run_poly(input string tag, input int mode, input int cready_pct, input int gap_pct);
      int k, done_cnt, done_cyc, last_hs, beats;
      logic held, took;
      logic [47:0] held_val;
      fed_q.delete();
      got_q.delete();
      done_cnt = 0; done_cyc = -10; last_hs = -20; beats = 0;
      held = 1'b0; took = 1'b0; held_val = '0;
      @(negedge clk);
      start = 1'b1; ivalid = 1'b0; cready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy after start"}, 128'(busy), 128'(1));
      for (int b = 0; b < 8; b++) ibytes[63-8*b -: 8] = src_byte(mode, b);
      k = 8;
      for (int cyc = 0; cyc < MAXC && done_cnt == 0; cyc++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (held) check({tag, " stall hold"}, 128'({cvalid, coeffs}), 128'({1'b1, held_val}));
         if (took) begin
            for (int b = 0; b < 8; b++) ibytes[63-8*b -: 8] = src_byte(mode, k + b);
            k += 8;
            took = 1'b0;
         end
         ivalid = ($urandom_range(99) >= gap_pct);
         cready = ($urandom_range(99) < cready_pct);
         start  = (mode == 2) && ($urandom_range(19) == 0);
         held     = cvalid && !cready;
         held_val = coeffs;
         if (cvalid && cready) begin
            for (int l = 0; l < 4; l++) got_q.push_back(int'(coeffs[47-12*l -: 12]));
            beats++;
            last_hs = cyc;
         end
         if (iready && ivalid) begin
            for (int b = 0; b < 8; b++) fed_q.push_back(int'(ibytes[63-8*b -: 8]));
            took = 1'b1;
         end
      end
      start = 1'b0;
      check({tag, " done pulses once (timeout if 0)"}, 128'(done_cnt), 128'(1));
      check({tag, " done one cycle after last beat"}, 128'(done_cyc - last_hs), 128'(1));
      check({tag, " beat count"}, 128'(beats), 128'(64));
      compare_model(tag, 256);
      @(negedge clk);
      check({tag, " idle after done"}, 128'({done, busy, iready}), 128'(0));
   endtask

   task automatic run_big();
      int done_cnt, beats, k;
      logic took;
      fed_q.delete();
      got_q.delete();
      done_cnt = 0; beats = 0; took = 1'b0;
      @(negedge clk);
      b_start = 1'b1; b_ivalid = 1'b0;
      @(negedge clk);
      b_start = 1'b0;
      for (int b = 0; b < 16; b++) b_ibytes[127-8*b -: 8] = src_byte(2, 0);
      k = 16;
      for (int cyc = 0; cyc < MAXC && done_cnt == 0; cyc++) begin
         @(negedge clk);
         if (b_done) done_cnt++;
         if (took) begin
            for (int b = 0; b < 16; b++) b_ibytes[127-8*b -: 8] = src_byte(2, k + b);
            k += 16;
            took = 1'b0;
         end
         b_ivalid = ($urandom_range(3) != 0);
         b_start  = ($urandom_range(3) == 0);
         if (b_cvalid) begin
            for (int l = 0; l < 8; l++) got_q.push_back(int'(b_coeffs[95-12*l -: 12]));
            beats++;
         end
         if (b_iready && b_ivalid) begin
            for (int b = 0; b < 16; b++) fed_q.push_back(int'(b_ibytes[127-8*b -: 8]));
            took = 1'b1;
         end
      end
      b_start = 1'b0;
      check("big done pulses once (timeout if 0)", 128'(done_cnt), 128'(1));
      check("big beat count", 128'(beats), 128'(8));
      compare_model("big", 64);
   endtask

   initial begin
      int seen, nb;
      rst = 1'b1;
      start = 1'b0; ivalid = 1'b0; cready = 1'b0; ibytes = '0;
      b_start = 1'b0; b_ivalid = 1'b0; b_ibytes = '0;
      repeat (3) @(negedge clk);
      check("reset outputs", 128'({iready, cvalid, coeffs, busy, done}), 128'(0));
      check("big reset outputs", 128'({b_iready, b_cvalid, b_coeffs, b_busy, b_done}), 128'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle without start", 128'({iready, busy, done}), 128'(0));

      run_poly("zero", 0, 100, 0);
      check("zero bytes consumed", 128'(fed_q.size() >= 384), 128'(1));

      run_poly("pat", 1, 100, 0);
      check("pat first d1", 128'(got_at(0)), 128'(769));
      check("pat first d2", 128'(got_at(1)), 128'(1106));

      run_poly("bnd", 4, 100, 0);
      check("bnd 3328 accepted", 128'(got_at(0)), 128'(3328));
      check("bnd d2 accepted", 128'(got_at(1)), 128'(0));
      check("bnd 3329 rejected", 128'(got_at(2)), 128'(0));
`ifdef PARSE_STREAM_REJ_STATS_EN
      check("bnd rej count", 128'(rej), 128'(1));
`endif

      run_poly("rnd", 2, 50, 30);

      run_big();

      // All-0xFF: every candidate is 4095, so nothing is ever emitted
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; ivalid = 1'b1; ibytes = '1; cready = 1'b1;
      seen = 0; nb = 0;
      for (int cyc = 0; cyc < 400 && nb < 100; cyc++) begin
         @(negedge clk);
         if (cvalid) seen++;
         if (done) seen++;
         if (iready) nb++;
      end
      check("ff beats accepted", 128'(nb), 128'(100));
      check("ff no output", 128'(seen), 128'(0));
      check("ff still busy", 128'(busy), 128'(1));
      rst = 1'b1;
      #1;
      check("mid-run reset outputs", 128'({iready, cvalid, coeffs, busy, done}), 128'(0));
`ifdef PARSE_STREAM_REJ_STATS_EN
      check("mid-run reset rej", 128'(rej), 128'(0));
`endif
      @(negedge clk);
      rst = 1'b0; ivalid = 1'b0;
      repeat (3) @(negedge clk);
      check("idle after reset", 128'({iready, cvalid, busy, done}), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
